// File: rtl/hack_sram_pkg.sv
// Shared types and default timing for the SRAM arbiter.
package hack_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WSETUP,
    WPULSE,
    WHOLD,
    DONE
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  localparam int ADDR_W_DEF   = 18;
  localparam int RD_WAIT_DEF  = 1;
  localparam int WR_PULSE_DEF = 2;
  localparam int WR_HOLD_DEF  = 1;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable 4-bit down-counter; zero flags the last cycle of a timed phase.
module sram_phase_timer (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin sequencer for an external asynchronous 16-bit SRAM.
// Strobes are registered from next_state so each phase starts cleanly on an edge.
module sram_arbiter
  import hack_sram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RD_WAIT  = RD_WAIT_DEF,
  parameter int WR_PULSE = WR_PULSE_DEF,
  parameter int WR_HOLD  = WR_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [15:0]       a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  output logic [15:0]       b_rdata,
  output logic              b_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dout,
  output logic              sram_doe,
  input  logic [15:0]       sram_din,
  output logic              sram_cen,
  output logic              sram_oen,
  output logic              sram_wen
);

  // Timer is loaded with length-1 so the zero flag marks the final cycle.
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WP_LOAD = 4'(WR_PULSE - 1);
  localparam logic [3:0] WH_LOAD = 4'(WR_HOLD - 1);

  state_t     state, next_state;
  port_t      grant, grant_nxt, last_grant;
  logic       take;
  logic       load;
  logic [3:0] load_val;
  logic       timer_zero;

  sram_phase_timer u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .load_val (load_val),
    .zero     (timer_zero)
  );

  always_comb begin
    next_state = state;
    grant_nxt  = grant;
    take       = 1'b0;
    load       = 1'b0;
    load_val   = RD_LOAD;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          take = 1'b1;
          if (a_req && b_req)
            grant_nxt = (last_grant == PORT_A) ? PORT_B : PORT_A;
          else
            grant_nxt = a_req ? PORT_A : PORT_B;
          if (grant_nxt == PORT_B && b_we) begin
            next_state = WSETUP;
          end else begin
            next_state = READ;
            load       = 1'b1;
            load_val   = RD_LOAD;
          end
        end
      end
      READ:   if (timer_zero) next_state = DONE;
      WSETUP: begin
        next_state = WPULSE;
        load       = 1'b1;
        load_val   = WP_LOAD;
      end
      WPULSE: begin
        if (timer_zero) begin
          next_state = WHOLD;
          load       = 1'b1;
          load_val   = WH_LOAD;
        end
      end
      WHOLD:  if (timer_zero) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      grant      <= PORT_A;
      last_grant <= PORT_B;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_cen   <= 1'b1;
      sram_oen   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_doe   <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      state    <= next_state;
      sram_cen <= !(next_state inside {READ, WSETUP, WPULSE, WHOLD});
      sram_oen <= (next_state != READ);
      sram_wen <= (next_state != WPULSE);
      sram_doe <= (next_state inside {WSETUP, WPULSE, WHOLD});
      a_ack    <= (next_state == DONE) && (grant == PORT_A);
      b_ack    <= (next_state == DONE) && (grant == PORT_B);
      if (take) begin
        grant      <= grant_nxt;
        last_grant <= grant_nxt;
        if (grant_nxt == PORT_A) begin
          sram_addr <= a_addr;
        end else begin
          sram_addr <= b_addr;
          sram_dout <= b_wdata;
        end
      end
      if (state == READ && timer_zero) begin
        if (grant == PORT_A) a_rdata <= sram_din;
        else                 b_rdata <= sram_din;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: default-timing arbiter (dut0) plus a slow-timing instance (dut1).
module tb_sram_arbiter;
  import hack_sram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rstn0, rstn1;
  logic        a_req0, a_req1, b_req0, b_req1, b_we0, b_we1;
  logic [17:0] a_addr0, a_addr1, b_addr0, b_addr1;
  logic [15:0] b_wdata0, b_wdata1;
  logic [15:0] a_rdata0, a_rdata1, b_rdata0, b_rdata1;
  logic        a_ack0, a_ack1, b_ack0, b_ack1;
  logic [17:0] addr0, addr1;
  logic [15:0] dout0, dout1, din0, din1;
  logic        doe0, doe1, cen0, cen1, oen0, oen1, wen0, wen1;

  sram_arbiter dut0 (
    .clk(clk), .rstn(rstn0),
    .a_req(a_req0), .a_addr(a_addr0), .a_rdata(a_rdata0), .a_ack(a_ack0),
    .b_req(b_req0), .b_we(b_we0), .b_addr(b_addr0), .b_wdata(b_wdata0),
    .b_rdata(b_rdata0), .b_ack(b_ack0),
    .sram_addr(addr0), .sram_dout(dout0), .sram_doe(doe0), .sram_din(din0),
    .sram_cen(cen0), .sram_oen(oen0), .sram_wen(wen0)
  );

  sram_arbiter #(.RD_WAIT(3), .WR_PULSE(4), .WR_HOLD(2)) dut1 (
    .clk(clk), .rstn(rstn1),
    .a_req(a_req1), .a_addr(a_addr1), .a_rdata(a_rdata1), .a_ack(a_ack1),
    .b_req(b_req1), .b_we(b_we1), .b_addr(b_addr1), .b_wdata(b_wdata1),
    .b_rdata(b_rdata1), .b_ack(b_ack1),
    .sram_addr(addr1), .sram_dout(dout1), .sram_doe(doe1), .sram_din(din1),
    .sram_cen(cen1), .sram_oen(oen1), .sram_wen(wen1)
  );

  // SRAM models: written cells return stored data, others a fixed pattern.
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];
  logic        wr0  [0:262143];
  logic        wr1  [0:262143];

  function automatic logic [15:0] dflt(input logic [17:0] a);
    if (a == 18'h00010) return 16'hBEEF;
    if (a == 18'h00005) return 16'h5555;
    return a[15:0] ^ 16'hA5A5;
  endfunction

  assign din0 = wr0[addr0] ? mem0[addr0] : dflt(addr0);
  assign din1 = wr1[addr1] ? mem1[addr1] : dflt(addr1);

  always @(posedge clk) begin
    if (!wen0 && doe0) begin mem0[addr0] <= dout0; wr0[addr0] <= 1'b1; end
    if (!wen1 && doe1) begin mem1[addr1] <= dout1; wr1[addr1] <= 1'b1; end
  end

  // One access on the selected DUT; starts in the next cycle, returns
  // observed latency and per-phase cycle counts, checks strobe invariants.
  task automatic acc(input bit sel, input bit port_b, input bit we,
                     input logic [17:0] addr, input logic [15:0] wdata,
                     output int lat, output int n_rd, output int n_wen,
                     output int n_hold, output int n_doe,
                     output logic [15:0] rdata, output logic [17:0] waddr,
                     output logic [15:0] wdat);
    bit seen_wen, ack, oen, doe, wen, cen;
    lat = 99; n_rd = 0; n_wen = 0; n_hold = 0; n_doe = 0;
    rdata = 'x; waddr = 'x; wdat = 'x; seen_wen = 0;
    @(negedge clk);
    if (sel == 0) begin
      if (port_b) begin b_req0 = 1; b_we0 = we; b_addr0 = addr; b_wdata0 = wdata; end
      else begin a_req0 = 1; a_addr0 = addr; end
    end else begin
      if (port_b) begin b_req1 = 1; b_we1 = we; b_addr1 = addr; b_wdata1 = wdata; end
      else begin a_req1 = 1; a_addr1 = addr; end
    end
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      cen = sel ? cen1 : cen0;
      oen = sel ? oen1 : oen0;
      wen = sel ? wen1 : wen0;
      doe = sel ? doe1 : doe0;
      n_checks += 2;
      if (!oen && doe) begin
        n_fail++;
        $display("FAIL inv_oen_doe dut%0d cycle %0d: oen=%b doe=%b, required not both active", sel, i, oen, doe);
      end
      if (!wen && !doe) begin
        n_fail++;
        $display("FAIL inv_wen_doe dut%0d cycle %0d: wen=%b doe=%b, required doe=1 when wen=0", sel, i, wen, doe);
      end
      if (!cen && !oen) n_rd++;
      if (doe) n_doe++;
      if (!wen) begin
        if (!seen_wen) begin
          waddr = sel ? addr1 : addr0;
          wdat  = sel ? dout1 : dout0;
        end
        n_wen++;
        seen_wen = 1;
      end else if (seen_wen && doe) n_hold++;
      ack = port_b ? (sel ? b_ack1 : b_ack0) : (sel ? a_ack1 : a_ack0);
      if (ack) begin
        lat = i;
        rdata = port_b ? (sel ? b_rdata1 : b_rdata0) : (sel ? a_rdata1 : a_rdata0);
        break;
      end
    end
    if (sel == 0) begin a_req0 = 0; b_req0 = 0; end
    else begin a_req1 = 0; b_req1 = 0; end
  endtask

  task automatic test_reset();
    rstn0 = 0; rstn1 = 0;
    a_req0 = 1; a_addr0 = 18'h00005; b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    a_req1 = 0; a_addr1 = '0; b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({cen0, oen0, wen0, doe0, a_ack0, b_ack0} !== 6'b111000) begin
        n_fail++;
        $display("FAIL reset_strobes cycle %0d: cen/oen/wen/doe/a_ack/b_ack=%b, required 111000", i,
                 {cen0, oen0, wen0, doe0, a_ack0, b_ack0});
      end
    end
    n_checks++;
    if (a_rdata0 !== 16'h0 || addr0 !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_regs: a_rdata=%h sram_addr=%h, required 0000 00000", a_rdata0, addr0);
    end
    rstn0 = 1; rstn1 = 1;
    @(negedge clk);
    n_checks++;
    if (cen0 !== 0 || oen0 !== 0 || dut0.state !== READ) begin
      n_fail++;
      $display("FAIL reset_first_grant: cen=%b oen=%b state=%0d, required 0 0 READ", cen0, oen0, dut0.state);
    end
    @(negedge clk);
    n_checks++;
    if (a_ack0 !== 1 || a_rdata0 !== 16'h5555) begin
      n_fail++;
      $display("FAIL reset_first_ack: a_ack=%b a_rdata=%h, required 1 5555", a_ack0, a_rdata0);
    end
    a_req0 = 0;
  endtask

  task automatic test_single_read();
    int lat, n_rd, n_wen, n_hold, n_doe;
    logic [15:0] rd, wd;
    logic [17:0] wa;
    acc(0, 0, 0, 18'h00010, 16'h0, lat, n_rd, n_wen, n_hold, n_doe, rd, wa, wd);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL read_latency: got %0d, required 2", lat); end
    n_checks++;
    if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL read_data: got %h, required beef", rd); end
    n_checks++;
    if (n_rd !== 1 || n_doe !== 0) begin
      n_fail++;
      $display("FAIL read_strobes: oen-low cycles %0d doe cycles %0d, required 1 0", n_rd, n_doe);
    end
  endtask

  task automatic test_single_write();
    int lat, n_rd, n_wen, n_hold, n_doe;
    logic [15:0] rd, wd;
    logic [17:0] wa;
    acc(0, 1, 1, 18'h3FFFF, 16'h1234, lat, n_rd, n_wen, n_hold, n_doe, rd, wa, wd);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL write_latency: got %0d, required 5", lat); end
    n_checks++;
    if (n_wen !== 2 || n_hold !== 1 || n_doe !== 4) begin
      n_fail++;
      $display("FAIL write_phases: wen-low %0d hold %0d doe %0d, required 2 1 4", n_wen, n_hold, n_doe);
    end
    n_checks++;
    if (wa !== 18'h3FFFF || wd !== 16'h1234) begin
      n_fail++;
      $display("FAIL write_bus: addr %h data %h, required 3ffff 1234", wa, wd);
    end
  endtask

  task automatic test_contention();
    bit seq [0:5];
    int n, overlap, cnt_a;
    n = 0; overlap = 0; cnt_a = 0;
    @(negedge clk);
    a_req0 = 1; a_addr0 = 18'h00010;
    b_req0 = 1; b_we0 = 0; b_addr0 = 18'h00005;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (a_ack0 && b_ack0) overlap++;
      if (a_ack0) begin seq[n] = 0; n++; cnt_a++; end
      else if (b_ack0) begin seq[n] = 1; n++; end
    end
    a_req0 = 0; b_req0 = 0;
    n_checks++;
    if (n !== 6 || overlap !== 0 || cnt_a !== 3) begin
      n_fail++;
      $display("FAIL contention_counts: acks %0d overlap %0d a-acks %0d, required 6 0 3", n, overlap, cnt_a);
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (seq[i] !== i[0]) begin
        n_fail++;
        $display("FAIL contention_order access %0d: port %s, required %s", i,
                 seq[i] ? "B" : "A", i[0] ? "B" : "A");
      end
    end
    n_checks++;
    if (a_rdata0 !== 16'hBEEF || b_rdata0 !== 16'h5555) begin
      n_fail++;
      $display("FAIL contention_data: a_rdata %h b_rdata %h, required beef 5555", a_rdata0, b_rdata0);
    end
  endtask

  task automatic test_readback();
    int lat, n_rd, n_wen, n_hold, n_doe;
    logic [15:0] rd, wd;
    logic [17:0] wa;
    acc(0, 0, 0, 18'h3FFFF, 16'h0, lat, n_rd, n_wen, n_hold, n_doe, rd, wa, wd);
    n_checks++;
    if (lat !== 2 || rd !== 16'h1234) begin
      n_fail++;
      $display("FAIL readback: latency %0d data %h, required 2 1234", lat, rd);
    end
  endtask

  task automatic test_mid_write_reset();
    int acks;
    acks = 0;
    @(negedge clk);
    b_req0 = 1; b_we0 = 1; b_addr0 = 18'h00100; b_wdata0 = 16'hAAAA;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut0.state !== WPULSE || wen0 !== 0) begin
      n_fail++;
      $display("FAIL midwr_setup: state %0d wen %b, required WPULSE 0", dut0.state, wen0);
    end
    rstn0 = 0;
    @(negedge clk);
    n_checks++;
    if (wen0 !== 1 || doe0 !== 0 || cen0 !== 1 || dut0.state !== IDLE) begin
      n_fail++;
      $display("FAIL midwr_abort: wen %b doe %b cen %b state %0d, required 1 0 1 IDLE", wen0, doe0, cen0, dut0.state);
    end
    if (b_ack0) acks++;
    b_req0 = 0;
    @(negedge clk);
    rstn0 = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_ack0) acks++;
    end
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("FAIL midwr_no_ack: %0d b_ack pulses, required 0", acks); end
  endtask

  task automatic test_param_sweep();
    int lat, n_rd, n_wen, n_hold, n_doe;
    logic [15:0] rd, wd;
    logic [17:0] wa;
    acc(1, 1, 1, 18'h00022, 16'h9876, lat, n_rd, n_wen, n_hold, n_doe, rd, wa, wd);
    n_checks++;
    if (lat !== 8 || n_wen !== 4 || n_hold !== 2) begin
      n_fail++;
      $display("FAIL sweep_write: latency %0d wen-low %0d hold %0d, required 8 4 2", lat, n_wen, n_hold);
    end
    acc(1, 0, 0, 18'h00022, 16'h0, lat, n_rd, n_wen, n_hold, n_doe, rd, wa, wd);
    n_checks++;
    if (lat !== 4 || n_rd !== 3 || rd !== 16'h9876) begin
      n_fail++;
      $display("FAIL sweep_read: latency %0d oen-low %0d data %h, required 4 3 9876", lat, n_rd, rd);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_readback();
    test_mid_write_reset();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the external 16-bit asynchronous SRAM (256K words) and shares it between two requesters.
- Port A is the CPU instruction-fetch path and is read-only. Port B is the memory-mapped program/data path and supports read and write.
- The block generates all SRAM strobes (cen/oen/wen), the address, and the data-out enable. The top level owns the inout pin and drives sram_data = sram_doe ? sram_dout : 'z.

Parameters:
- ADDR_W, 18, SRAM address width.
- RD_WAIT, 1, cycles oen/cen stay low before read data is sampled (1..15).
- WR_PULSE, 2, cycles wen stays low (1..15).
- WR_HOLD, 1, cycles address/data stay driven after wen rises (1..15).

Ports:
- clk  in  1  system clock (100 MHz)
- rstn  in  1  reset
- a_req  in  1  fetch request (level)
- a_addr  in  ADDR_W  fetch address
- a_rdata  out  16  fetch read data, valid when a_ack=1
- a_ack  out  1  one-cycle completion pulse
- b_req  in  1  aux request (level)
- b_we  in  1  1=write, 0=read
- b_addr  in  ADDR_W  aux address
- b_wdata  in  16  aux write data
- b_rdata  out  16  aux read data, valid when b_ack=1
- b_ack  out  1  one-cycle completion pulse
- sram_addr  out  ADDR_W  SRAM address
- sram_dout  out  16  SRAM write data
- sram_doe  out  1  1 = drive sram_data pins
- sram_din  in  16  SRAM pin data (read path)
- sram_cen  out  1  chip enable, active low
- sram_oen  out  1  output enable, active low
- sram_wen  out  1  write enable, active low

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk. While rstn=0, the next edge forces:
  - state=IDLE, cen=oen=wen=1, doe=0
  - a_ack=b_ack=0, a_rdata=b_rdata=0, sram_addr=0, sram_dout=0
  - last_grant=B, so A wins the first tie.
- Reset mid-operation: the same edge aborts the access. Strobes rise, no ack is issued, and an interrupted write leaves SRAM content undefined.
- Outputs are registered. A 4-bit down-counter times every phase.
- States:
  - IDLE: cen=oen=wen=1, doe=0, sram_addr holds its last value.
    - Evaluates requests every cycle. A lone requester is granted. If both request, grant the port not equal to last_grant (round-robin), then update last_grant.
    - On grant, latch the address (and wdata/we for B).
    - Go to READ if the port is A or b_we=0; go to WSETUP otherwise.
  - READ: cen=0, oen=0, for RD_WAIT cycles. On the final edge, register sram_din into the granted port's rdata and go to DONE.
  - WSETUP: one cycle. Address and data driven, doe=1, cen=0, wen=1. Then go to WPULSE.
  - WPULSE: wen=0, cen=0, doe=1, oen=1, for WR_PULSE cycles. Then go to WHOLD.
  - WHOLD: wen=1, cen=0, doe=1, for WR_HOLD cycles. Then go to DONE.
  - DONE: one cycle. The granted port's ack=1, all strobes inactive, doe=0, no grant evaluated. Then go to IDLE.
- Invariants:
  - oen=0 and doe=1 are never asserted in the same cycle.
  - wen=0 implies doe=1.
- Latency, with the request sampled in IDLE at cycle t:
  - Read: ack in cycle t+RD_WAIT+1. With the default RD_WAIT=1, ack at t+2.
  - Write: ack in cycle t+WR_PULSE+WR_HOLD+2. With defaults, t+5.
- Handshake:
  - Requester holds req, addr, we and wdata stable until it sees ack.
  - Requester must deassert req in the cycle after ack unless it wants another access. Because DONE does not grant, a req still high in the IDLE cycle after DONE counts as a new request.
  - rdata holds its value until that port's next read completes.
- Inputs changing after grant are ignored, because they are latched at grant.
- Address wrap is not applicable: the full ADDR_W is passed through unmodified.

Decomposition:
- Package hack_sram_pkg holds:
  - state enum: IDLE, READ, WSETUP, WPULSE, WHOLD, DONE
  - PORT_A/PORT_B grant encoding
  - default timing constants
- Sub-module sram_phase_timer: a loadable 4-bit down-counter with a zero flag, used by READ, WPULSE and WHOLD.
- The FSM, arbitration and output registers stay in sram_arbiter.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with a_req=1 -> cen=oen=wen=1, doe=0, no ack. After release, A is granted on the first edge.
- Single read: a_req=1, a_addr=0x00010, SRAM model returns 0xBEEF -> cen/oen low for 1 cycle, a_ack high at t+2, a_rdata=0xBEEF, doe never 1.
- Single write: b_req=1, b_we=1, b_addr=0x3FFFF, b_wdata=0x1234 -> WSETUP 1 cycle, wen low for exactly 2 cycles, data driven 1 cycle after wen rises, b_ack at t+5. A read-back via A returns 0x1234.
- Contention: a_req and b_req held high simultaneously for 6 accesses -> grants strictly alternate A,B,A,B,A,B. No ack overlap, and each port completes 3 accesses.
- Mid-write reset: assert rstn=0 in the second WPULSE cycle -> the next edge sets wen=1, doe=0, state IDLE, and b_ack is never pulsed.
- Parameter sweep: RD_WAIT=3, WR_PULSE=4, WR_HOLD=2 -> read ack at t+4, write ack at t+8. The strobe-exclusion invariants hold in every cycle (checked by assertion).
